// File: rtl/p_strb_splitter.sv
// p_strb_splitter
// Write-strobe generator and width splitter for the AHB-to-APB bridge write
// path. Takes one captured AHB write request, masks its strobes to the bytes
// that the size/address actually cover, and issues it as a sequence of
// PDATA_W-bit APB beats. Beats with no enabled byte are skipped, and an
// illegal size/alignment produces a one-cycle size_err pulse instead of beats.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst        - synchronous active-high reset
//   req_valid  - request present (sampled only while req_ready=1)
//   req_ready  - block can accept a request
//   req_addr   - transfer address (HADDR)
//   req_size   - transfer size (HSIZE), bytes = 2^req_size
//   req_wstrb  - AHB write strobes, one per AHB byte lane
//   req_wdata  - AHB write data
//   beat_valid - APB beat available
//   beat_ready - APB FSM consumes the beat
//   beat_addr  - PB-aligned beat address
//   beat_wdata - beat data slice
//   beat_strb  - beat PSTRB
//   beat_last  - final beat of the request
//   size_err   - one-cycle pulse for an illegal request
//
// The design assumes HDATA_W >= 16 (at least two AHB byte lanes) and
// ADDR_W >= 8.

module p_strb_splitter #(
    parameter int HDATA_W = 64,
    parameter int PDATA_W = 32,
    parameter int ADDR_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [2:0]             req_size,
    input  logic [HDATA_W/8-1:0]   req_wstrb,
    input  logic [HDATA_W-1:0]     req_wdata,
    output logic                   beat_valid,
    input  logic                   beat_ready,
    output logic [ADDR_W-1:0]      beat_addr,
    output logic [PDATA_W-1:0]     beat_wdata,
    output logic [PDATA_W/8-1:0]   beat_strb,
    output logic                   beat_last,
    output logic                   size_err
);

    localparam int HB    = HDATA_W / 8;
    localparam int PB    = PDATA_W / 8;
    localparam int NBEAT = HDATA_W / PDATA_W;
    localparam int HB_LG = $clog2(HB);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               next_state_s;

    // Captured request: address, data, effective strobes and pending beats.
    logic [ADDR_W-1:0]    addr_r;
    logic [HDATA_W-1:0]   wdata_r;
    logic [HB-1:0]        eff_r;
    logic [NBEAT-1:0]     pend_r;

    logic [ADDR_W-1:0]    addr_n_s;
    logic [HDATA_W-1:0]   wdata_n_s;
    logic [HB-1:0]        eff_n_s;
    logic [NBEAT-1:0]     pend_n_s;

    // Request decode.
    logic [8:0]           size_bytes_s;
    logic [7:0]           low_mask_s;
    logic [HB_LG-1:0]     off_s;
    logic                 legal_s;
    logic [HB-1:0]        mask_s;
    logic [HB-1:0]        eff_calc_s;
    logic [NBEAT-1:0]     pend_calc_s;
    logic [NBEAT-1:0]     lowbit_s;

    // Next values of the registered outputs.
    int                   sel_s;
    logic                 req_ready_n_s;
    logic                 size_err_n_s;
    logic                 beat_valid_n_s;
    logic [ADDR_W-1:0]    beat_addr_n_s;
    logic [PDATA_W-1:0]   beat_wdata_n_s;
    logic [PB-1:0]        beat_strb_n_s;
    logic                 beat_last_n_s;

    // Decode legality, byte mask, effective strobes and pending beats of the incoming request.
    always_comb begin
        size_bytes_s = 9'd1 << req_size;
        low_mask_s   = size_bytes_s[7:0] - 8'd1;
        off_s        = req_addr[HB_LG-1:0];
        legal_s      = (req_size <= 3'(HB_LG)) && ((req_addr[7:0] & low_mask_s) == 8'd0);
        for (int k = 0; k < HB; k++) begin
            mask_s[k] = (k >= int'(off_s)) && (k < int'(off_s) + int'(size_bytes_s));
        end
        eff_calc_s = req_wstrb & mask_s;
        if (eff_calc_s == {HB{1'b0}}) begin
            // No enabled byte: still issue the beat holding the start byte so
            // the APB side sees a (strb 0) write and the transfer completes.
            for (int i = 0; i < NBEAT; i++) begin
                pend_calc_s[i] = (i == int'(off_s) / PB);
            end
        end else begin
            for (int i = 0; i < NBEAT; i++) begin
                pend_calc_s[i] = |eff_calc_s[i*PB +: PB];
            end
        end
    end

    // Isolate the lowest pending beat, i.e. the one currently presented.
    always_comb begin
        lowbit_s = pend_r & (~pend_r + NBEAT'(1'b1));
    end

    // Next-state logic, including capture of the request and retirement of beats.
    always_comb begin
        next_state_s = state_r;
        addr_n_s     = addr_r;
        wdata_n_s    = wdata_r;
        eff_n_s      = eff_r;
        pend_n_s     = pend_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_n_s  = req_addr;
                    wdata_n_s = req_wdata;
                    eff_n_s   = eff_calc_s;
                    if (legal_s) begin
                        pend_n_s     = pend_calc_s;
                        next_state_s = ST_SEND;
                    end else begin
                        pend_n_s     = {NBEAT{1'b0}};
                        next_state_s = ST_ERR;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                // beat_valid is high throughout SEND, so beat_ready alone is the handshake.
                if (beat_ready) begin
                    pend_n_s = pend_r & ~lowbit_s;
                    if ((pend_r & ~lowbit_s) == {NBEAT{1'b0}}) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_SEND;
                    end
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_ERR: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                pend_n_s     = {NBEAT{1'b0}};
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so that every output leaves a flop.
    always_comb begin
        req_ready_n_s  = (next_state_s == ST_IDLE);
        size_err_n_s   = (next_state_s == ST_ERR);
        beat_valid_n_s = 1'b0;
        beat_addr_n_s  = {ADDR_W{1'b0}};
        beat_wdata_n_s = {PDATA_W{1'b0}};
        beat_strb_n_s  = {PB{1'b0}};
        beat_last_n_s  = 1'b0;
        sel_s          = 0;
        // Scan downwards so the lowest pending beat wins.
        for (int i = NBEAT - 1; i >= 0; i--) begin
            sel_s = pend_n_s[i] ? i : sel_s;
        end
        if (next_state_s == ST_SEND) begin
            beat_valid_n_s = 1'b1;
            beat_addr_n_s  = {addr_n_s[ADDR_W-1:HB_LG], {HB_LG{1'b0}}} | ADDR_W'(sel_s * PB);
            beat_wdata_n_s = wdata_n_s[sel_s*PDATA_W +: PDATA_W];
            beat_strb_n_s  = eff_n_s[sel_s*PB +: PB];
            beat_last_n_s  = ((pend_n_s & (pend_n_s - NBEAT'(1'b1))) == {NBEAT{1'b0}});
        end else begin
            beat_valid_n_s = 1'b0;
        end
    end

    // State, captured request and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {HDATA_W{1'b0}};
            eff_r      <= {HB{1'b0}};
            pend_r     <= {NBEAT{1'b0}};
            req_ready  <= 1'b0;
            size_err   <= 1'b0;
            beat_valid <= 1'b0;
            beat_addr  <= {ADDR_W{1'b0}};
            beat_wdata <= {PDATA_W{1'b0}};
            beat_strb  <= {PB{1'b0}};
            beat_last  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            addr_r     <= addr_n_s;
            wdata_r    <= wdata_n_s;
            eff_r      <= eff_n_s;
            pend_r     <= pend_n_s;
            req_ready  <= req_ready_n_s;
            size_err   <= size_err_n_s;
            beat_valid <= beat_valid_n_s;
            beat_addr  <= beat_addr_n_s;
            beat_wdata <= beat_wdata_n_s;
            beat_strb  <= beat_strb_n_s;
            beat_last  <= beat_last_n_s;
        end
    end

endmodule

// File: tb/tb_p_strb_splitter.sv
module tb_p_strb_splitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_wstrb;
    logic [63:0] req_wdata;
    logic        beat_valid;
    logic        beat_ready;
    logic [31:0] beat_addr;
    logic [31:0] beat_wdata;
    logic [3:0]  beat_strb;
    logic        beat_last;
    logic        size_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    p_strb_splitter #(.HDATA_W(64), .PDATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
        .beat_wdata(beat_wdata), .beat_strb(beat_strb), .beat_last(beat_last),
        .size_err(size_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge; caller knows req_ready is 1.
    task automatic send_req(input logic [31:0] a, input logic [2:0] s,
                            input logic [7:0] st, input logic [63:0] d);
        req_valid = 1'b1; req_addr = a; req_size = s; req_wstrb = st; req_wdata = d;
        tick();
        req_valid = 1'b0; req_addr = 32'h0; req_size = 3'd0; req_wstrb = 8'h0; req_wdata = 64'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; beat_ready = 1'b0;
        req_addr = 32'h0; req_size = 3'd0; req_wstrb = 8'h0; req_wdata = 64'h0;
        tick(); tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
        checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", beat_valid); end
        checks++; if (size_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", size_err); end
        checks++; if (beat_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", beat_addr); end
        rst = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", req_ready); end
    endtask

    task automatic test_byte();
        send_req(32'h1005, 3'd0, 8'hFF, 64'h1122334455667788);
        checks++; if (beat_valid !== 1'b1) begin errors++; $display("FAIL byte_valid got %b exp 1", beat_valid); end
        checks++; if (beat_addr !== 32'h1004) begin errors++; $display("FAIL byte_addr got %h exp 1004", beat_addr); end
        checks++; if (beat_strb !== 4'b0010) begin errors++; $display("FAIL byte_strb got %b exp 0010", beat_strb); end
        checks++; if (beat_wdata !== 32'h11223344) begin errors++; $display("FAIL byte_wdata got %h exp 11223344", beat_wdata); end
        checks++; if (beat_last !== 1'b1) begin errors++; $display("FAIL byte_last got %b exp 1", beat_last); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL byte_busy got %b exp 0", req_ready); end
        beat_ready = 1'b1;
        tick();
        beat_ready = 1'b0;
        checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL byte_done_valid got %b exp 0", beat_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL byte_done_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_dword();
        send_req(32'h2000, 3'd3, 8'hFF, 64'hCAFEF00DDEADBEEF);
        beat_ready = 1'b1;
        checks++; if (beat_valid !== 1'b1) begin errors++; $display("FAIL dw_b0_valid got %b exp 1", beat_valid); end
        checks++; if (beat_addr !== 32'h2000) begin errors++; $display("FAIL dw_b0_addr got %h exp 2000", beat_addr); end
        checks++; if (beat_strb !== 4'hF) begin errors++; $display("FAIL dw_b0_strb got %h exp f", beat_strb); end
        checks++; if (beat_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dw_b0_wdata got %h exp deadbeef", beat_wdata); end
        checks++; if (beat_last !== 1'b0) begin errors++; $display("FAIL dw_b0_last got %b exp 0", beat_last); end
        tick();
        checks++; if (beat_valid !== 1'b1) begin errors++; $display("FAIL dw_b1_valid got %b exp 1", beat_valid); end
        checks++; if (beat_addr !== 32'h2004) begin errors++; $display("FAIL dw_b1_addr got %h exp 2004", beat_addr); end
        checks++; if (beat_strb !== 4'hF) begin errors++; $display("FAIL dw_b1_strb got %h exp f", beat_strb); end
        checks++; if (beat_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL dw_b1_wdata got %h exp cafef00d", beat_wdata); end
        checks++; if (beat_last !== 1'b1) begin errors++; $display("FAIL dw_b1_last got %b exp 1", beat_last); end
        tick();
        beat_ready = 1'b0;
        checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL dw_done_valid got %b exp 0", beat_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL dw_done_ready got %b exp 1", req_ready); end
        // Upper-half strobes only: the empty low beat is skipped.
        send_req(32'h2000, 3'd3, 8'hF0, 64'h0123456789ABCDEF);
        checks++; if (beat_addr !== 32'h2004) begin errors++; $display("FAIL dwhi_addr got %h exp 2004", beat_addr); end
        checks++; if (beat_strb !== 4'hF) begin errors++; $display("FAIL dwhi_strb got %h exp f", beat_strb); end
        checks++; if (beat_wdata !== 32'h01234567) begin errors++; $display("FAIL dwhi_wdata got %h exp 01234567", beat_wdata); end
        checks++; if (beat_last !== 1'b1) begin errors++; $display("FAIL dwhi_last got %b exp 1", beat_last); end
        beat_ready = 1'b1;
        tick();
        beat_ready = 1'b0;
        checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL dwhi_done_valid got %b exp 0", beat_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL dwhi_done_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_illegal();
        logic [31:0] addrs [2];
        logic [2:0]  sizes [2];
        addrs[0] = 32'h1001; sizes[0] = 3'd1;
        addrs[1] = 32'h1000; sizes[1] = 3'd4;
        beat_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            send_req(addrs[n], sizes[n], 8'hFF, 64'hFFFFFFFFFFFFFFFF);
            checks++; if (size_err !== 1'b1) begin errors++; $display("FAIL ill%0d_err got %b exp 1", n, size_err); end
            checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL ill%0d_valid got %b exp 0", n, beat_valid); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ill%0d_busy got %b exp 0", n, req_ready); end
            tick();
            checks++; if (size_err !== 1'b0) begin errors++; $display("FAIL ill%0d_err_pulse got %b exp 0", n, size_err); end
            checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL ill%0d_valid2 got %b exp 0", n, beat_valid); end
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ill%0d_ready got %b exp 1", n, req_ready); end
        end
        beat_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        send_req(32'h4000, 3'd3, 8'hFF, 64'h8765432112345678);
        for (int c = 0; c < 3; c++) begin
            checks++; if (beat_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_valid got %b exp 1", c, beat_valid); end
            checks++; if (beat_addr !== 32'h4000) begin errors++; $display("FAIL bp%0d_addr got %h exp 4000", c, beat_addr); end
            checks++; if (beat_strb !== 4'hF) begin errors++; $display("FAIL bp%0d_strb got %h exp f", c, beat_strb); end
            checks++; if (beat_wdata !== 32'h12345678) begin errors++; $display("FAIL bp%0d_wdata got %h exp 12345678", c, beat_wdata); end
            checks++; if (beat_last !== 1'b0) begin errors++; $display("FAIL bp%0d_last got %b exp 0", c, beat_last); end
            if (c < 2) tick();
        end
        beat_ready = 1'b1;
        tick();
        checks++; if (beat_valid !== 1'b1) begin errors++; $display("FAIL bp_b1_valid got %b exp 1", beat_valid); end
        checks++; if (beat_addr !== 32'h4004) begin errors++; $display("FAIL bp_b1_addr got %h exp 4004", beat_addr); end
        checks++; if (beat_wdata !== 32'h87654321) begin errors++; $display("FAIL bp_b1_wdata got %h exp 87654321", beat_wdata); end
        checks++; if (beat_last !== 1'b1) begin errors++; $display("FAIL bp_b1_last got %b exp 1", beat_last); end
        tick();
        beat_ready = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_done_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_zero_strb();
        send_req(32'h3004, 3'd2, 8'h00, 64'hAABBCCDD55667788);
        checks++; if (beat_valid !== 1'b1) begin errors++; $display("FAIL zs_valid got %b exp 1", beat_valid); end
        checks++; if (beat_addr !== 32'h3004) begin errors++; $display("FAIL zs_addr got %h exp 3004", beat_addr); end
        checks++; if (beat_strb !== 4'h0) begin errors++; $display("FAIL zs_strb got %h exp 0", beat_strb); end
        checks++; if (beat_wdata !== 32'hAABBCCDD) begin errors++; $display("FAIL zs_wdata got %h exp aabbccdd", beat_wdata); end
        checks++; if (beat_last !== 1'b1) begin errors++; $display("FAIL zs_last got %b exp 1", beat_last); end
        beat_ready = 1'b1;
        tick();
        beat_ready = 1'b0;
        checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL zs_done_valid got %b exp 0", beat_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zs_done_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_reset_mid();
        send_req(32'h5000, 3'd3, 8'hFF, 64'h0000000100000002);
        checks++; if (beat_valid !== 1'b1) begin errors++; $display("FAIL rm_valid got %b exp 1", beat_valid); end
        rst = 1'b1;
        tick();
        checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL rm_abort_valid got %b exp 0", beat_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rm_abort_ready got %b exp 0", req_ready); end
        rst = 1'b0;
        beat_ready = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", req_ready); end
        checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL rm_no_beat1 got %b exp 0", beat_valid); end
        tick();
        checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL rm_no_beat1_late got %b exp 0", beat_valid); end
        beat_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_byte();
        test_dword();
        test_illegal();
        test_backpressure();
        test_zero_strb();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p_strb_splitter.md
Name: p_strb_splitter

Overview:
Parametrised write-strobe generator and width splitter for the AHB-to-APB bridge write path.
- Accepts one registered AHB write (address, HSIZE, write strobes, data) on a HDATA_W-bit bus.
- Masks the strobes to the bytes the size/address actually cover.
- Splits the transfer into PDATA_W-bit APB beats, each with its own PSTRB.
- Skips beats with no enabled bytes and flags illegal size/alignment.
- Sits between the bridge's captured-request registers and the APB setup/access FSM.

Parameters:
- HDATA_W, 64, AHB data width in bits; power of 2, multiple of PDATA_W.
- PDATA_W, 32, APB data width in bits; power of 2, >= 8.
- ADDR_W, 32, address width.
- Derived values:
  - HB = HDATA_W/8, AHB byte lanes.
  - PB = PDATA_W/8, APB byte lanes.
  - NBEAT = HDATA_W/PDATA_W, maximum beats per request.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  transfer address (HADDR)
- req_size  in  3  transfer size (HSIZE), bytes = 2^req_size
- req_wstrb  in  HB  AHB write strobes
- req_wdata  in  HDATA_W  AHB write data
- beat_valid  out  1  APB beat available
- beat_ready  in  1  APB FSM consumes beat
- beat_addr  out  ADDR_W  PB-aligned beat address
- beat_wdata  out  PDATA_W  beat data slice
- beat_strb  out  PB  beat PSTRB
- beat_last  out  1  final beat of request
- size_err  out  1  one-cycle error pulse

Behaviour:
- Reset (rst=1 at edge):
  - State goes to IDLE and all outputs go to 0, including req_ready.
  - req_ready=1 from the first cycle after rst deasserts.
  - Reset mid-transfer aborts it; no further beats are issued.
- Legality check, evaluated at acceptance:
  - A request is legal iff 2^req_size <= HB and req_addr mod 2^req_size == 0.
  - Any other request is illegal, including req_size > log2(HB).
- Byte enable for a legal request:
  - off = req_addr mod HB.
  - mask bit k = 1 for off <= k < off + 2^req_size.
  - eff = req_wstrb & mask.
- Beat selection:
  - Beat i covers eff[i*PB +: PB] and data req_wdata[i*PDATA_W +: PDATA_W].
  - pend[i] = |eff slice i.
  - If eff == 0, pend holds only the beat containing off, so the transfer still completes with strb 0.
- Beat address: {req_addr[ADDR_W-1:log2(HB)], i, log2(PB) zeros}.
- States and transitions:
  - IDLE: req_ready=1.
    - On req_valid: capture addr, wdata and eff, and compute pend. req_ready goes to 0 next cycle.
    - Illegal request -> ERR. Legal request -> SEND.
  - ERR: size_err=1 for exactly one cycle, no beats issued, then -> IDLE.
  - SEND: beat_valid=1, presenting the lowest set bit of pend.
    - beat_last=1 iff that bit is the only one set.
    - On beat_valid & beat_ready, that bit is cleared.
    - If that was the last bit -> IDLE, with beat_valid=0 the next cycle.
- Latency:
  - Request accepted at edge N gives beat_valid high in cycle N+1.
  - On a handshake at edge M, the next beat is valid in cycle M+1 (no bubble).
  - After the last beat, req_ready=1 in the following cycle. Minimum spacing is NBEAT_used+1 cycles per request.
- Handshake rules:
  - While beat_valid=1 and beat_ready=0, all beat_* outputs hold stable.
  - beat_ready is ignored while beat_valid=0.
  - req_* inputs are ignored while req_ready=0.
- Outputs are registered; beat_* are 0 outside SEND.
- Degenerate case: with NBEAT==1, every legal request yields exactly one beat with beat_last=1.

Test Plan:
All scenarios use HDATA_W=64, PDATA_W=32.
1. Byte write: addr 0x1005, size 0, wstrb 0xFF -> one beat: addr 0x1004, strb 0b0010, wdata=req_wdata[63:32], last=1, 1-cycle latency.
2. Dword write: addr 0x2000, size 3, wstrb 0xFF -> two beats: 0x2000 strb 0xF, then 0x2004 strb 0xF with last=1. Repeat with wstrb 0xF0 -> single beat 0x2004 strb 0xF, last=1.
3. Illegal requests: addr 0x1001 size 1 -> size_err high for exactly 1 cycle, beat_valid never asserted, req_ready=1 two cycles after accept. Repeat with size 4 -> same response.
4. Backpressure: dword request with beat_ready low for 3 cycles on beat 0 -> beat_addr/strb/wdata/last unchanged across all 3 cycles. Beat 1 valid the cycle after the handshake.
5. Zero strobes: word write at addr 0x3004, size 2, wstrb 0x00 -> one beat: addr 0x3004, strb 0x0, last=1.
6. Reset mid-transfer: rst=1 during beat 0 of a 2-beat request -> beat_valid=0 and req_ready=0 next cycle, no beat 1. req_ready=1 one cycle after rst drops.
